// File: rtl/nco_sweep_ctrl_pkg.sv
// Shared types for the NCO sweep controller: FSM state encoding, sample tag
// carried alongside the NCO pipeline, and default widths.
package nco_ctrl_pkg;

  localparam int unsigned APR_DEF   = 32;
  localparam int unsigned LAT_DEF   = 6;
  localparam int unsigned NST_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } nco_ctrl_state_t;

  // Tag step field is fixed at NST_W_DEF bits; the controller's NST_W must not exceed it.
  typedef struct packed {
    logic                 v;
    logic [NST_W_DEF-1:0] step;
    logic                 last_step;
    logic                 last_sweep;
  } nco_tag_t;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// NCO-side and sample-stream signals of the sweep controller, grouped so the
// controller, the NCO wrapper and the FFT front end share one bundle.
interface nco_sweep_ctrl_if #(
  parameter int unsigned APR   = 32,
  parameter int unsigned NST_W = 8
);
  // Handshake: a sample moves on every cycle where nco_clken=1, which the
  // controller only raises while ds_ready=1; smp_valid marks which of those
  // cycles carry a tagged NCO output, and the smp_* fields are zero otherwise.
  logic             ds_ready;
  logic             nco_out_valid;
  logic [APR-1:0]   nco_phi_inc;
  logic             nco_clken;
  logic             smp_valid;
  logic [NST_W-1:0] smp_step;
  logic             smp_last_step;
  logic             smp_last_sweep;

  modport master (
    input  ds_ready, nco_out_valid,
    output nco_phi_inc, nco_clken, smp_valid, smp_step, smp_last_step, smp_last_sweep
  );

  modport slave (
    output ds_ready, nco_out_valid,
    input  nco_phi_inc, nco_clken, smp_valid, smp_step, smp_last_step, smp_last_sweep
  );
endinterface

// File: rtl/nco_tag_pipe.sv
// Tag delay line matching the NCO latency; advances only when the NCO is
// clock-enabled so tags stay aligned with samples under any backpressure.
module nco_tag_pipe
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEF
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     en,
  input  logic     flush,
  input  nco_tag_t tag_i,
  output nco_tag_t tag_o,
  output logic     any_valid,
  output logic     upstream_valid
);

  nco_tag_t pipe_q [LAT];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < int'(LAT); i++) pipe_q[i] <= '0;
    end else if (en) begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < int'(LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[LAT-1];

  // upstream_valid ignores the output stage: it tells whether anything tagged
  // would remain after the current output tag shifts out.
  always_comb begin
    any_valid      = 1'b0;
    upstream_valid = 1'b0;
    for (int i = 0; i < int'(LAT); i++) begin
      any_valid = any_valid | pipe_q[i].v;
      if (i < int'(LAT) - 1) upstream_valid = upstream_valid | pipe_q[i].v;
    end
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Sweep sequencer for the NCO: steps phi_inc through a tone/chirp schedule,
// gates the NCO clock enable from downstream backpressure and frames samples.
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int unsigned APR   = APR_DEF,
  parameter int unsigned SPS_W = 16,
  parameter int unsigned NST_W = NST_W_DEF,
  parameter int unsigned LAT   = LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [APR-1:0]    cfg_start_inc,
  input  logic [APR-1:0]    cfg_step_inc,
  input  logic [NST_W-1:0]  cfg_num_steps,
  input  logic [SPS_W-1:0]  cfg_samples,
  input  logic              cfg_continuous,
  input  logic              start,
  input  logic              abort,
  nco_sweep_ctrl_if.master  nco,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output nco_ctrl_state_t   dbg_state
);

  nco_ctrl_state_t  state_q, state_d;
  logic [APR-1:0]   phi_q, phi_d;
  logic [SPS_W-1:0] cnt_q, cnt_d;
  logic [NST_W-1:0] step_q, step_d;
  logic [APR-1:0]   start_inc_q, start_inc_d;
  logic [APR-1:0]   step_inc_q, step_inc_d;
  logic [NST_W-1:0] num_steps_q, num_steps_d;
  logic [SPS_W-1:0] samples_q, samples_d;
  logic             cont_q, cont_d;

  logic     clken;
  logic     last_smp;
  logic     last_stp;
  nco_tag_t tag_push;
  nco_tag_t tag_out;
  logic     any_valid;
  logic     upstream_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phi_q       <= '0;
      cnt_q       <= '0;
      step_q      <= '0;
      start_inc_q <= '0;
      step_inc_q  <= '0;
      num_steps_q <= '0;
      samples_q   <= '0;
      cont_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phi_q       <= phi_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      start_inc_q <= start_inc_d;
      step_inc_q  <= step_inc_d;
      num_steps_q <= num_steps_d;
      samples_q   <= samples_d;
      cont_q      <= cont_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phi_d       = phi_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    start_inc_d = start_inc_q;
    step_inc_d  = step_inc_q;
    num_steps_d = num_steps_q;
    samples_d   = samples_q;
    cont_d      = cont_q;
    clken       = 1'b0;
    done        = 1'b0;
    cfg_err     = 1'b0;
    tag_push    = '0;
    last_smp    = (cnt_q == samples_q - SPS_W'(1));
    last_stp    = (step_q == num_steps_q - NST_W'(1));

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_samples == '0) begin
              cfg_err = 1'b1;
            end else begin
              start_inc_d = cfg_start_inc;
              step_inc_d  = cfg_step_inc;
              num_steps_d = (cfg_num_steps == '0) ? NST_W'(1) : cfg_num_steps;
              samples_d   = cfg_samples;
              cont_d      = cfg_continuous;
              phi_d       = cfg_start_inc;
              cnt_d       = '0;
              step_d      = '0;
              state_d     = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          clken               = nco.ds_ready;
          tag_push.v          = 1'b1;
          tag_push.step       = NST_W_DEF'(step_q);
          tag_push.last_step  = last_smp;
          tag_push.last_sweep = last_smp && last_stp;
          if (clken) begin
            if (last_smp) begin
              cnt_d  = '0;
              phi_d  = phi_q + step_inc_q;
              step_d = step_q + NST_W'(1);
              // End of sweep: loop back with continuous phase, or let the pipe empty.
              if (last_stp) begin
                if (cont_q) begin
                  phi_d  = start_inc_q;
                  step_d = '0;
                end else begin
                  state_d = ST_DRAIN;
                end
              end
            end else begin
              cnt_d = cnt_q + SPS_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          clken = nco.ds_ready;
          if (!any_valid || (clken && !upstream_valid)) state_d = ST_FIN;
        end
        ST_FIN: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  nco_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk            (clk),
    .reset          (reset),
    .en             (clken),
    .flush          (abort),
    .tag_i          (tag_push),
    .tag_o          (tag_out),
    .any_valid      (any_valid),
    .upstream_valid (upstream_valid)
  );

  assign busy               = (state_q != ST_IDLE);
  assign dbg_state          = state_q;
  assign nco.nco_phi_inc    = phi_q;
  assign nco.nco_clken      = clken;
  assign nco.smp_valid      = clken & tag_out.v & nco.nco_out_valid;
  assign nco.smp_step       = nco.smp_valid ? NST_W'(tag_out.step) : '0;
  assign nco.smp_last_step  = nco.smp_valid & tag_out.last_step;
  assign nco.smp_last_sweep = nco.smp_valid & tag_out.last_sweep;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Bench for nco_sweep_ctrl: behavioural sweep model plus an NCO stand-in,
// checked every cycle, with hand-computed expectations for the directed cases.
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;
  import nco_ctrl_pkg::*;

  localparam int APR   = 32;
  localparam int SPS_W = 16;
  localparam int NST_W = 8;
  localparam int LAT   = 6;
  localparam int W     = 1 + APR + NST_W + 2;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [APR-1:0]   cfg_start_inc, cfg_step_inc;
  logic [NST_W-1:0] cfg_num_steps;
  logic [SPS_W-1:0] cfg_samples;
  logic             cfg_continuous, start, abort;
  logic             busy, done, cfg_err;
  nco_ctrl_state_t  dbg_state;

  nco_sweep_ctrl_if #(.APR(APR), .NST_W(NST_W)) bus ();

  nco_sweep_ctrl #(.APR(APR), .SPS_W(SPS_W), .NST_W(NST_W), .LAT(LAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start_inc  (cfg_start_inc),
    .cfg_step_inc   (cfg_step_inc),
    .cfg_num_steps  (cfg_num_steps),
    .cfg_samples    (cfg_samples),
    .cfg_continuous (cfg_continuous),
    .start          (start),
    .abort          (abort),
    .nco            (bus),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .dbg_state      (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- NCO stand-in ----------------
  // Fills after LAT enabled cycles and delays phi_inc by LAT enables.
  int             nco_fill = 0;
  logic [APR-1:0] nco_q[$];
  logic           clken_s = 1'b0, reset_s = 1'b1;
  logic [APR-1:0] phi_s = '0;
  logic [APR-1:0] nco_phi_out;

  initial for (int i = 0; i < LAT; i++) nco_q.push_back('0);
  assign bus.nco_out_valid = (nco_fill >= LAT);
  assign nco_phi_out       = nco_q[0];

  always @(posedge clk) begin
    if (reset_s) nco_fill = 0;
    else if (clken_s && nco_fill < LAT) nco_fill++;
    if (clken_s) begin
      nco_q.push_back(phi_s);
      void'(nco_q.pop_front());
    end
  end

  // ---------------- behavioural model ----------------
  logic [W-1:0]   exp_q[$];
  bit             m_run = 0, m_drain = 0, m_fin = 0, m_cont = 0;
  int             m_n = 0, m_ns = 1, m_sp = 1;
  logic [APR-1:0] m_phi = '0, m_si = '0, m_sd = '0;

  initial for (int i = 0; i < LAT; i++) exp_q.push_back('0);

  // ---------------- event logs ----------------
  int             cyc = 0;
  int             start_cyc = 0;
  int             smp_cyc_q[$];
  int             smp_step_q[$];
  bit             lw_flag_q[$];
  logic [APR-1:0] smp_phi_q[$];
  int             done_q[$];
  int             lw_cyc = 0, lw_idx = -1, lw_n = 0, cfg_err_n = 0, clken_bad_n = 0;

  task automatic clear_logs();
    smp_cyc_q.delete(); smp_step_q.delete(); lw_flag_q.delete(); smp_phi_q.delete();
    done_q.delete();
    lw_cyc = 0; lw_idx = -1; lw_n = 0; cfg_err_n = 0; clken_bad_n = 0;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [W-1:0]   front, ent;
    bit             idle, e_clken, e_sv, any_v;
    int             st;
    bit             ls, lw;
    logic [APR-1:0] k;
    cyc++;
    clken_s = bus.nco_clken;
    phi_s   = bus.nco_phi_inc;
    reset_s = reset;

    idle    = !(m_run || m_drain || m_fin);
    front   = exp_q[0];
    e_clken = (m_run || m_drain) && bus.ds_ready && !abort;
    e_sv    = e_clken && front[W-1] && bus.nco_out_valid;

    chk("busy", busy, !idle);
    chk("done", done, m_fin && !abort);
    chk("cfg_err", cfg_err, idle && start && !abort && (cfg_samples == '0));
    chk("nco_clken", bus.nco_clken, e_clken);
    chk("nco_phi_inc", bus.nco_phi_inc, m_phi);
    chk("smp_valid", bus.smp_valid, e_sv);
    chk("smp_step", bus.smp_step, e_sv ? front[NST_W+1:2] : '0);
    chk("smp_last_step", bus.smp_last_step, e_sv && front[1]);
    chk("smp_last_sweep", bus.smp_last_sweep, e_sv && front[0]);
    if (e_sv) chk("out_phase_inc", nco_phi_out, front[W-2 -: APR]);

    if (bus.smp_valid) begin
      smp_cyc_q.push_back(cyc);
      smp_step_q.push_back(int'(bus.smp_step));
      lw_flag_q.push_back(bus.smp_last_sweep);
      smp_phi_q.push_back(nco_phi_out);
      if (bus.smp_last_sweep) begin
        lw_n++; lw_cyc = cyc; lw_idx = smp_cyc_q.size() - 1;
      end
    end
    if (done) done_q.push_back(cyc);
    if (cfg_err) cfg_err_n++;
    if (!bus.ds_ready && bus.nco_clken) clken_bad_n++;

    // model advance
    if (reset) begin
      m_run = 0; m_drain = 0; m_fin = 0; m_phi = '0;
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back('0);
    end else if (abort) begin
      m_run = 0; m_drain = 0; m_fin = 0;
      exp_q.delete();
      for (int i = 0; i < LAT; i++) exp_q.push_back('0);
    end else if (m_fin) begin
      m_fin = 0;
    end else if (idle) begin
      if (start && cfg_samples != '0) begin
        start_cyc = cyc;
        m_si = cfg_start_inc; m_sd = cfg_step_inc;
        m_ns = (cfg_num_steps == '0) ? 1 : int'(cfg_num_steps);
        m_sp = int'(cfg_samples); m_cont = cfg_continuous;
        m_n = 0; m_phi = cfg_start_inc; m_run = 1;
      end
    end else begin
      if (e_clken) begin
        if (m_run) begin
          st = m_n / m_sp;
          ls = (m_n % m_sp) == m_sp - 1;
          lw = ls && (st == m_ns - 1);
          ent = {1'b1, m_phi, NST_W'(st), ls, lw};
          exp_q.push_back(ent);
          m_n++;
          if (m_n % m_sp == 0) begin
            k = APR'(m_n / m_sp);
            m_phi = m_si + k * m_sd;
            if (m_n == m_ns * m_sp) begin
              if (m_cont) begin m_n = 0; m_phi = m_si; end
              else begin m_run = 0; m_drain = 1; end
            end
          end
        end else begin
          exp_q.push_back('0);
        end
        void'(exp_q.pop_front());
      end
      if (m_drain) begin
        any_v = 0;
        foreach (exp_q[i]) any_v |= exp_q[i][W-1];
        if (!any_v) begin m_drain = 0; m_fin = 1; end
      end
    end
  end

  // ---------------- driver ----------------
  int ds_mode = 0;
  int ds_idx  = 0;

  task automatic drive_ds();
    case (ds_mode)
      0:       bus.ds_ready = 1'b1;
      1:       bus.ds_ready = (ds_idx % 4 == 0) || (ds_idx % 4 == 3);
      default: bus.ds_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic step_clk();
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    ds_idx++;
    drive_ds();
  endtask

  task automatic set_cfg(input logic [APR-1:0] si, input logic [APR-1:0] sd,
                         input int ns, input int sp, input bit cont);
    cfg_start_inc  = si;
    cfg_step_inc   = sd;
    cfg_num_steps  = NST_W'(ns);
    cfg_samples    = SPS_W'(sp);
    cfg_continuous = cont;
  endtask

  // Starts a non-continuous sweep from IDLE and runs it to its done pulse.
  task automatic run_sweep(input int mode, input bit inject);
    ds_mode = mode; ds_idx = 0; drive_ds();
    clear_logs();
    start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      step_clk();
      if (done_q.size() > 0) break;
      if (inject && busy && $urandom_range(0, 7) == 0) start = 1'b1;
    end
    chk("sweep_done_count", done_q.size(), 1);
  endtask

  task automatic check_framing(input string tag);
    chk({tag, "_smp_count"}, smp_cyc_q.size(), 12);
    if (smp_cyc_q.size() > 0) chk({tag, "_first_latency"}, smp_cyc_q[0] - start_cyc, 7);
    for (int i = 0; i < smp_step_q.size() && i < 12; i++)
      chk({tag, "_step_seq"}, smp_step_q[i], i / 4);
    chk({tag, "_last_sweep_n"}, lw_n, 1);
    chk({tag, "_last_sweep_idx"}, lw_idx, 11);
    if (done_q.size() > 0) chk({tag, "_done_after_last"}, done_q[0] - lw_cyc, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cont_steps[12];
    bit cont_lw[12];
    int n_keep, ns, sp;
    cont_steps = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    cont_lw    = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; bus.ds_ready = 1'b0;
    set_cfg('0, '0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_phi", bus.nco_phi_inc, 0);
    chk("reset_clken", bus.nco_clken, 0);
    chk("reset_smp_valid", bus.smp_valid, 0);
    chk("reset_state", dbg_state, ST_IDLE);
    step_clk();

    // directed: 3 steps x 4 samples, ready held high
    set_cfg(32'h0100_0000, 32'h0010_0000, 3, 4, 0);
    run_sweep(0, 0);
    check_framing("t1");
    chk("t1_phi_step2", smp_phi_q.size() > 8 ? smp_phi_q[8] : '0, 32'h0120_0000);

    // same schedule under 1,0,0,1 backpressure
    run_sweep(1, 0);
    chk("t2_smp_count", smp_cyc_q.size(), 12);
    for (int i = 0; i < smp_step_q.size() && i < 12; i++) chk("t2_step_seq", smp_step_q[i], i / 4);
    chk("t2_last_sweep_idx", lw_idx, 11);
    if (done_q.size() > 0) chk("t2_done_after_last", done_q[0] - lw_cyc, 1);
    chk("t2_clken_while_not_ready", clken_bad_n, 0);

    // phase-increment wrap between steps
    set_cfg(32'hFFFF_FFF0, 32'h0000_0020, 2, 3, 0);
    run_sweep(0, 0);
    chk("t3_smp_count", smp_cyc_q.size(), 6);
    if (smp_phi_q.size() > 3) begin
      chk("t3_phi_step0", smp_phi_q[0], 32'hFFFF_FFF0);
      chk("t3_phi_step1", smp_phi_q[3], 32'h0000_0010);
    end

    // continuous sweep, then abort
    set_cfg(32'h0000_1000, 32'h0000_0100, 2, 2, 1);
    ds_mode = 0; ds_idx = 0; drive_ds();
    clear_logs();
    start = 1'b1;
    repeat (30) step_clk();
    chk("t4_enough_samples", smp_cyc_q.size() >= 12, 1);
    for (int i = 0; i < smp_step_q.size() && i < 12; i++) begin
      chk("t4_step_seq", smp_step_q[i], cont_steps[i]);
      chk("t4_last_sweep_flag", lw_flag_q[i], cont_lw[i]);
    end
    chk("t4_no_done", done_q.size(), 0);
    abort = 1'b1;
    step_clk();
    chk("t4_busy_after_abort", busy, 0);
    chk("t4_clken_after_abort", bus.nco_clken, 0);
    n_keep = smp_cyc_q.size();
    repeat (10) step_clk();
    chk("t4_no_samples_after_abort", smp_cyc_q.size(), n_keep);

    // zero samples per step is rejected
    set_cfg(32'h1, 32'h1, 2, 0, 0);
    clear_logs();
    start = 1'b1;
    #1;
    chk("t5_cfg_err_pulse", cfg_err, 1);
    step_clk();
    chk("t5_busy_stays_low", busy, 0);
    repeat (3) step_clk();
    chk("t5_cfg_err_count", cfg_err_n, 1);
    chk("t5_still_idle", busy, 0);

    // synchronous reset in the middle of ISSUE
    set_cfg(32'h0100_0000, 32'h0010_0000, 3, 4, 0);
    ds_mode = 0; ds_idx = 0; drive_ds();
    start = 1'b1;
    repeat (9) step_clk();
    reset = 1'b1;
    step_clk();
    reset = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_cfg_err", cfg_err, 0);
    chk("t6_clken", bus.nco_clken, 0);
    chk("t6_phi", bus.nco_phi_inc, 0);
    chk("t6_smp_valid", bus.smp_valid, 0);
    chk("t6_state", dbg_state, ST_IDLE);
    step_clk();

    // randomized sweeps with random backpressure and ignored starts
    for (int r = 0; r < 8; r++) begin
      ns = $urandom_range(0, 4);
      sp = $urandom_range(1, 5);
      set_cfg($urandom, $urandom, ns, sp, 0);
      run_sweep(2, 1);
      chk("rnd_smp_count", smp_cyc_q.size(), (ns == 0 ? 1 : ns) * sp);
      chk("rnd_last_sweep_n", lw_n, 1);
      if (done_q.size() > 0) chk("rnd_done_after_last", done_q[0] - lw_cyc, 1);
      repeat ($urandom_range(0, 3)) step_clk();
    end

    repeat (2) step_clk();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
